// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and FSM state type for the operand fetch controller
package regfile_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/wb_buffer.sv
// rtl/wb_buffer.sv - one-entry writeback holding register with drain and forwarding compare
module wb_buffer
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wbValid,
  output logic              wbReady,
  input  logic [ADDR_W-1:0] wbReg,
  input  logic [DATA_W-1:0] wbData,
  input  logic              drain_ok,
  output logic              CONTROL_REG_WRITE,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] fwd_idx1,
  input  logic [ADDR_W-1:0] fwd_idx2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data
);

  logic              pend;
  logic [ADDR_W-1:0] held_reg;
  logic [DATA_W-1:0] held_data;
  logic              load;

  assign CONTROL_REG_WRITE = pend && drain_ok;
  assign wbReady           = !pend || CONTROL_REG_WRITE;
  // Writes to register zero are swallowed here so they never occupy the entry.
  assign load              = wbValid && wbReady && (wbReg != ZERO_REG);

  assign writeReg  = pend ? held_reg  : '0;
  assign writeData = pend ? held_data : '0;
  assign fwd_hit1  = pend && (held_reg == fwd_idx1);
  assign fwd_hit2  = pend && (held_reg == fwd_idx2);
  assign fwd_data  = held_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend      <= 1'b0;
      held_reg  <= '0;
      held_data <= '0;
    end else if (load) begin
      pend      <= 1'b1;
      held_reg  <= wbReg;
      held_data <= wbData;
    end else if (CONTROL_REG_WRITE) begin
      pend      <= 1'b0;
    end
  end

endmodule

// File: rtl/operand_fetch_ctrl.sv
// rtl/operand_fetch_ctrl.sv - register-file initiator: operand fetch FSM with buffered, forwarded writeback
module operand_fetch_ctrl
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              rspValid,
  input  logic              rspReady,
  output logic [DATA_W-1:0] operand1,
  output logic [DATA_W-1:0] operand2,
  input  logic              wbValid,
  output logic              wbReady,
  input  logic [ADDR_W-1:0] wbReg,
  input  logic [DATA_W-1:0] wbData,
  output logic [ADDR_W-1:0] readReg1,
  output logic [ADDR_W-1:0] readReg2,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              CONTROL_REG_WRITE
);

  state_t            state;
  logic [ADDR_W-1:0] rs_q;
  logic [ADDR_W-1:0] rt_q;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] fetch_val1;
  logic [DATA_W-1:0] fetch_val2;

  assign reqReady = (state == IDLE);
  assign rspValid = (state == RESP);
  assign readReg1 = (state == IDLE) ? ZERO_REG : rs_q;
  assign readReg2 = (state == IDLE) ? ZERO_REG : rt_q;

  // Draining is held off in READ so the read ports see a quiet register file.
  wb_buffer u_wb_buffer (
    .clk               (clk),
    .reset             (reset),
    .wbValid           (wbValid),
    .wbReady           (wbReady),
    .wbReg             (wbReg),
    .wbData            (wbData),
    .drain_ok          (state != READ),
    .CONTROL_REG_WRITE (CONTROL_REG_WRITE),
    .writeReg          (writeReg),
    .writeData         (writeData),
    .fwd_idx1          (rs_q),
    .fwd_idx2          (rt_q),
    .fwd_hit1          (fwd_hit1),
    .fwd_hit2          (fwd_hit2),
    .fwd_data          (fwd_data)
  );

  assign fetch_val1 = (rs_q == ZERO_REG) ? '0 : (fwd_hit1 ? fwd_data : readData1);
  assign fetch_val2 = (rt_q == ZERO_REG) ? '0 : (fwd_hit2 ? fwd_data : readData2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rs_q     <= '0;
      rt_q     <= '0;
      operand1 <= '0;
      operand2 <= '0;
    end else begin
      case (state)
        IDLE: if (reqValid) begin
          state <= READ;
          rs_q  <= rs;
          rt_q  <= rt;
        end
        READ: begin
          state    <= RESP;
          operand1 <= fetch_val1;
          operand2 <= fetch_val2;
        end
        RESP: if (rspReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/operand_fetch_ctrl.md
# operand_fetch_ctrl

Initiator-side controller for the processor register file. It accepts operand-fetch requests and writeback requests from the pipeline, and drives the register file's read ports (`readReg1`, `readReg2`) and write port (`writeReg`, `writeData`, `CONTROL_REG_WRITE`). It returns captured operands over a valid/ready handshake and buffers one pending writeback. It forwards buffered writeback data so fetched operands are never stale.

## Interface
- `ADDR_W`, 5, register index width
- `DATA_W`, 32, register data width
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `reqValid` in 1: fetch request valid
- `reqReady` out 1: fetch request accepted when high with `reqValid`
- `rs`, `rt` in ADDR_W: source register indices
- `rspValid` out 1: operands valid
- `rspReady` in 1: consumer accepts operands
- `operand1`, `operand2` out DATA_W: fetched values for `rs`/`rt`
- `wbValid` in 1: writeback request valid
- `wbReady` out 1: writeback accepted when high with `wbValid`
- `wbReg` in ADDR_W, `wbData` in DATA_W: writeback target and value
- `readReg1`, `readReg2` out ADDR_W: register-file read addresses
- `readData1`, `readData2` in DATA_W: register-file read data (combinational response)
- `writeReg` out ADDR_W, `writeData` out DATA_W, `CONTROL_REG_WRITE` out 1: register-file write port

## Operation
- FSM states:
  - IDLE → READ on `reqValid && reqReady`; latch `rs`/`rt`.
  - READ → RESP unconditionally; capture operands at the exit edge.
  - RESP → IDLE on `rspValid && rspReady`.
- `reqReady` = (state == IDLE).
- `rspValid` = (state == RESP).
- `readReg1`/`readReg2` drive the latched indices in READ and RESP, and 0 in IDLE.
- Writeback buffer: a single entry (`wbPend`, reg, data).
  - `wbReady` = `!wbPend || CONTROL_REG_WRITE`, so back-to-back writebacks drain at one per cycle.
  - Load on `wbValid && wbReady`.
  - A writeback with `wbReg == 0` is accepted and discarded; it never sets `wbPend`.
- Drain: `CONTROL_REG_WRITE` = `wbPend && state != READ` (combinational). `writeReg`/`writeData` drive the buffer contents; when `wbPend` = 0 they drive 0.
  - `wbPend` clears at the edge ending a drain cycle, unless a new writeback loads at the same edge.
  - Writes are blocked in READ, so the read ports are never disturbed while data settles.
- Operand capture at the READ→RESP edge:
  - Index 0 gives 0.
  - Otherwise, if `wbPend` and the buffer reg equals the index, the operand is the buffer data (forwarding).
  - Otherwise the operand is `readData1`/`readData2`.
- Ordering rule: operands reflect every writeback accepted before the capture edge. A writeback accepted at the capture edge itself is not visible.
- Operands hold stable throughout RESP.

## Timing
- Reset values:
  - state IDLE.
  - `reqReady` 1, `wbReady` 1.
  - `rspValid` 0, `CONTROL_REG_WRITE` 0.
  - `operand1`/`operand2` 0, all address and data outputs 0.
  - `wbPend` 0.
- Latency: request accepted at edge T gives `rspValid` high from T+2. Throughput is at most one fetch per 3 cycles.
- Writeback accepted at edge T with state IDLE or RESP in cycle T+1: `CONTROL_REG_WRITE` is high for exactly cycle T+1. A READ cycle delays it by one cycle.
- Simultaneous `reqValid` and `wbValid` in IDLE with an empty buffer: both accepted. The write is held through READ, forwarded at capture, and written in the first RESP cycle.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight fetch and any pending writeback are dropped.
- No combinational path from `readData*` to any output except through the operand registers.

## Structure
- Package `regfile_pkg`:
  - `ADDR_W`, `DATA_W`, and `ZERO_REG` = 0.
  - FSM state typedef (IDLE, READ, RESP).
- Sub-module `wb_buffer`: the one-entry writeback holding register. It provides the ready/valid logic, the drain output, and the compare used for forwarding.

## Test plan
- **Basic fetch:** preload reg3 = 0x11 and reg4 = 0x22. Request rs = 3, rt = 4 accepted at edge T → `rspValid` high at T+2 with `operand1` = 0x11 and `operand2` = 0x22.
- **Writeback then read:** writeback reg5 = 0xDEAD in IDLE → `CONTROL_REG_WRITE` high for exactly one cycle with `writeReg` = 5. A later fetch of rs = 5 returns 0xDEAD.
- **Forwarding:** in the same cycle, request rs = 7 and writeback reg7 = 0xBEEF (reg7 holds 0x1) → `operand1` = 0xBEEF. `CONTROL_REG_WRITE` stays low during READ and goes high in the first RESP cycle.
- **Register zero:** writeback reg0 = 0xFFFF → `CONTROL_REG_WRITE` never asserts. A fetch of rs = 0 returns 0.
- **Backpressure:** hold `rspReady` = 0 for 5 cycles in RESP → operands stable and `reqReady` = 0. Two back-to-back writebacks drain on consecutive cycles. `rspReady` = 1 → IDLE the next cycle.
- **Reset mid-READ:** assert `reset` during READ with a pending writeback → all outputs take reset values immediately. No write occurs after reset is released.
